// File: rtl/rom_reader_if.sv
// Bundle of command, ROM-port and output-stream signals between rom_reader and its neighbours.
// master: the rom_reader side; slave: the controller/ROM/consumer side.
interface rom_reader_if #(
  parameter int unsigned m = 8,
  parameter int unsigned n = 4
);
  localparam int unsigned aw = (m > 1) ? $clog2(m) : 1;

  logic          start;
  logic [aw-1:0] base;
  logic [aw:0]   len;
  logic          busy;
  logic          done;
  logic [aw-1:0] rom_addr;
  logic [n-1:0]  rom_data;
  logic [n-1:0]  data_o;
  logic          valid_o;
  logic          ready_i;

  modport master (
    input  start, base, len, rom_data, ready_i,
    output busy, done, rom_addr, data_o, valid_o
  );

  modport slave (
    output start, base, len, rom_data, ready_i,
    input  busy, done, rom_addr, data_o, valid_o
  );
endinterface

// File: rtl/rom_reader.sv
// Burst reader for a 1-cycle registered ROM: issues len addresses from base (wrapping at m)
// and streams the words out through a 4-entry FIFO with valid/ready backpressure.
module rom_reader #(
  parameter int unsigned m = 8,
  parameter int unsigned n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  rom_reader_if.master bus
);
  localparam int unsigned Aw    = (m > 1) ? $clog2(m) : 1;
  localparam int unsigned Depth = 4;

  localparam logic [Aw:0]   LenOne   = (Aw+1)'(1);
  localparam logic [Aw-1:0] AddrOne  = Aw'(1);
  localparam logic [Aw-1:0] AddrLast = Aw'(m - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e        state_q, state_d;
  logic [Aw-1:0] addr_q, addr_d;
  logic [Aw:0]   remain_q, remain_d;  // addresses still to issue
  logic [Aw:0]   left_q, left_d;      // words still to hand over
  logic          v1_q, v1_d;          // address presented, ROM not yet registered
  logic          v2_q, v2_d;          // ROM output valid, captured on next edge
  logic [2:0]    cnt_q, cnt_d;
  logic [1:0]    wr_q, wr_d;
  logic [1:0]    rd_q, rd_d;
  logic [n-1:0]  mem_q [Depth];
  logic [n-1:0]  mem_d [Depth];
  logic          done_q, done_d;

  logic accept, accept_run, push, pop, credit_ok, issue_run, last_pop;

  always_comb begin
    accept     = (state_q == StIdle) && bus.start;
    accept_run = accept && (bus.len != '0);
    push       = v2_q;
    pop        = (cnt_q != 3'd0) && bus.ready_i;
    // Words in the FIFO plus words in the ROM pipe may never exceed the FIFO depth.
    credit_ok  = ({1'b0, cnt_q} + 4'(v1_q) + 4'(v2_q)) < 4'(Depth);
    issue_run  = (state_q == StRun) && (remain_q != '0) && credit_ok;
    last_pop   = pop && (left_q == LenOne);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept_run) state_d = StRun;
      end
      StRun: begin
        if ((remain_q == '0) || (issue_run && (remain_q == LenOne))) state_d = StDrain;
      end
      StDrain: begin
        if (last_pop) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy     = (state_q != StIdle);
    bus.done     = done_q;
    bus.rom_addr = addr_q;
    bus.data_o   = mem_q[rd_q];
    bus.valid_o  = (cnt_q != 3'd0);
  end

  // Datapath next-state
  always_comb begin
    addr_d   = addr_q;
    remain_d = remain_q;
    left_d   = left_q;
    mem_d    = mem_q;
    if (accept_run) begin
      addr_d   = bus.base;
      remain_d = bus.len - LenOne;
      left_d   = bus.len;
    end else begin
      if (issue_run) begin
        addr_d   = (addr_q == AddrLast) ? '0 : addr_q + AddrOne;
        remain_d = remain_q - LenOne;
      end
      if (pop) left_d = left_q - LenOne;
    end
    v1_d = accept_run || issue_run;
    v2_d = v1_q;
    if (push) mem_d[wr_q] = bus.rom_data;
    wr_d   = wr_q + {1'b0, push};
    rd_d   = rd_q + {1'b0, pop};
    cnt_d  = cnt_q + {2'b0, push} - {2'b0, pop};
    done_d = (accept && (bus.len == '0)) || last_pop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q   <= '0;
      remain_q <= '0;
      left_q   <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      cnt_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      mem_q    <= '{default: '0};
      done_q   <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      remain_q <= remain_d;
      left_q   <= left_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      mem_q    <= mem_d;
      done_q   <= done_d;
    end
  end
endmodule
